// File: rtl/sysmon_pkg.sv
// sysmon_pkg -- shared definitions for the SYSMON DRP poller.
//   poll_state_e    : poller FSM states
//   IDX_*           : sweep index of each monitored channel
//   DRP_ADDR_TABLE  : SYSMON status register address for each sweep index
//   drp_addr_of()   : table lookup from sweep index to DRP address
package sysmon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_NEXT    = 3'd4
  } poll_state_e;

  localparam logic [1:0] IDX_TEMP    = 2'd0;
  localparam logic [1:0] IDX_VCCINT  = 2'd1;
  localparam logic [1:0] IDX_VCCAUX  = 2'd2;
  localparam logic [1:0] IDX_VCCBRAM = 2'd3;

  // Entry i is the DRP address read at sweep index i (VCCBRAM lives at 06h).
  localparam logic [3:0][7:0] DRP_ADDR_TABLE = {8'h06, 8'h02, 8'h01, 8'h00};

  function automatic logic [7:0] drp_addr_of(input logic [1:0] idx);
    return DRP_ADDR_TABLE[idx];
  endfunction

endpackage

// File: rtl/sysmon_drp_poller.sv
// sysmon_drp_poller -- periodically sweeps four SYSMON status registers over
// the DRP and publishes the latest raw readings plus health flags.
//   clk_200, reset          : 200 MHz clock (also SYSMON DCLK), async active-high reset
//   drp_daddr/den/dwe/di    : DRP request side (read-only use: dwe and di tied low)
//   drp_do, drp_drdy        : DRP read data and data-ready
//   jtag_locked             : JTAG currently owns the DRP; requests are held off
//   temp/vccint/vccaux/vccbram : latest raw readings
//   valid                   : per-channel "captured at least once" flags
//   update                  : one-cycle pulse per captured reading
//   over_temp               : hysteretic over-temperature flag
//   timeout_err             : sticky DRDY timeout flag
//   sweep_count             : completed sweeps, wrapping
module sysmon_drp_poller
  import sysmon_pkg::*;
#(
  parameter int unsigned POLL_INTERVAL = 200000,
  parameter int unsigned DRP_TIMEOUT   = 63,
  parameter logic [15:0] TEMP_HI       = 16'hB6C0,
  parameter logic [15:0] TEMP_LO       = 16'hB400
) (
  input  logic        clk_200,
  input  logic        reset,
  output logic [7:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  input  logic        jtag_locked,
  output logic [15:0] temp,
  output logic [15:0] vccint,
  output logic [15:0] vccaux,
  output logic [15:0] vccbram,
  output logic [3:0]  valid,
  output logic        update,
  output logic        over_temp,
  output logic        timeout_err,
  output logic [15:0] sweep_count
);

  localparam logic [31:0] INTERVAL_LAST = 32'(POLL_INTERVAL - 32'd1);
  localparam logic [15:0] TIMEOUT_LAST  = 16'(DRP_TIMEOUT - 32'd1);

  poll_state_e state_r;
  poll_state_e state_s;
  logic [1:0]  idx_r;
  logic [31:0] interval_cnt_r;
  logic [15:0] timeout_cnt_r;
  logic [7:0]  daddr_r;
  logic        den_r;
  logic [15:0] temp_r;
  logic [15:0] vccint_r;
  logic [15:0] vccaux_r;
  logic [15:0] vccbram_r;
  logic [3:0]  valid_r;
  logic        update_r;
  logic        over_temp_r;
  logic        timeout_err_r;
  logic [15:0] sweep_cnt_r;

  logic        tick_s;
  logic        issue_s;
  logic        capture_s;
  logic        expire_s;
  logic        sweep_done_s;

  assign tick_s = (interval_cnt_r == INTERVAL_LAST);

  // Next-state and per-cycle event decode for the poller FSM.
  always_comb begin
    state_s      = state_r;
    issue_s      = 1'b0;
    capture_s    = 1'b0;
    expire_s     = 1'b0;
    sweep_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (jtag_locked) begin
          state_s = ST_ISSUE;
        end else begin
          issue_s = 1'b1;
          state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // DRDY wins over an expiry landing in the same cycle.
        if (drp_drdy) begin
          capture_s = 1'b1;
          state_s   = ST_CAPTURE;
        end else if (timeout_cnt_r >= TIMEOUT_LAST) begin
          expire_s = 1'b1;
          state_s  = ST_NEXT;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_CAPTURE: begin
        state_s = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_r == IDX_VCCBRAM) begin
          sweep_done_s = 1'b1;
          state_s      = ST_IDLE;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_200 or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Free-running sweep interval counter; an overrun sweep simply waits for the next wrap.
  always_ff @(posedge clk_200 or posedge reset) begin
    if (reset) begin
      interval_cnt_r <= 32'd0;
    end else if (tick_s) begin
      interval_cnt_r <= 32'd0;
    end else begin
      interval_cnt_r <= interval_cnt_r + 32'd1;
    end
  end

  // Sweep index and per-read DRDY wait counter.
  always_ff @(posedge clk_200 or posedge reset) begin
    if (reset) begin
      idx_r         <= 2'd0;
      timeout_cnt_r <= 16'd0;
    end else begin
      if (state_r == ST_IDLE && tick_s) begin
        idx_r <= IDX_TEMP;
      end else if (state_r == ST_NEXT && !sweep_done_s) begin
        idx_r <= idx_r + 2'd1;
      end
      if (issue_s) begin
        timeout_cnt_r <= 16'd0;
      end else if (state_r == ST_WAIT) begin
        timeout_cnt_r <= timeout_cnt_r + 16'd1;
      end
    end
  end

  // DRP request outputs: DEN is a single-cycle pulse, the address is held until the next issue.
  always_ff @(posedge clk_200 or posedge reset) begin
    if (reset) begin
      den_r   <= 1'b0;
      daddr_r <= 8'h00;
    end else begin
      den_r <= issue_s;
      if (issue_s) begin
        daddr_r <= drp_addr_of(idx_r);
      end
    end
  end

  // Reading capture straight off the DRDY edge so the outputs land one cycle after DRDY.
  always_ff @(posedge clk_200 or posedge reset) begin
    if (reset) begin
      temp_r      <= 16'h0000;
      vccint_r    <= 16'h0000;
      vccaux_r    <= 16'h0000;
      vccbram_r   <= 16'h0000;
      valid_r     <= 4'b0000;
      update_r    <= 1'b0;
      over_temp_r <= 1'b0;
    end else begin
      update_r <= capture_s;
      if (capture_s) begin
        valid_r[idx_r] <= 1'b1;
        case (idx_r)
          IDX_TEMP: begin
            temp_r <= drp_do;
            if (drp_do >= TEMP_HI) begin
              over_temp_r <= 1'b1;
            end else if (drp_do <= TEMP_LO) begin
              over_temp_r <= 1'b0;
            end
          end
          IDX_VCCINT:  vccint_r  <= drp_do;
          IDX_VCCAUX:  vccaux_r  <= drp_do;
          IDX_VCCBRAM: vccbram_r <= drp_do;
          default: begin
          end
        endcase
      end
    end
  end

  // Sticky timeout flag and wrapping sweep counter.
  always_ff @(posedge clk_200 or posedge reset) begin
    if (reset) begin
      timeout_err_r <= 1'b0;
      sweep_cnt_r   <= 16'h0000;
    end else begin
      if (expire_s) begin
        timeout_err_r <= 1'b1;
      end
      if (sweep_done_s) begin
        sweep_cnt_r <= sweep_cnt_r + 16'd1;
      end
    end
  end

  assign drp_daddr   = daddr_r;
  assign drp_den     = den_r;
  assign drp_dwe     = 1'b0;
  assign drp_di      = 16'h0000;
  assign temp        = temp_r;
  assign vccint      = vccint_r;
  assign vccaux      = vccaux_r;
  assign vccbram     = vccbram_r;
  assign valid       = valid_r;
  assign update      = update_r;
  assign over_temp   = over_temp_r;
  assign timeout_err = timeout_err_r;
  assign sweep_count = sweep_cnt_r;

endmodule

// File: tb/tb_sysmon_drp_poller.sv
// tb_sysmon_drp_poller -- randomized bench for sysmon_drp_poller with a
// behavioural DRP responder and a per-sweep expectation model.
module tb_sysmon_drp_poller;

  localparam int unsigned POLL = 100;
  localparam int unsigned TMO  = 63;
  localparam logic [15:0] T_HI = 16'hB6C0;
  localparam logic [15:0] T_LO = 16'hB400;

  logic        clk_200 = 1'b0;
  logic        reset;
  logic [7:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        jtag_locked;
  logic [15:0] temp, vccint, vccaux, vccbram;
  logic [3:0]  valid;
  logic        update, over_temp, timeout_err;
  logic [15:0] sweep_count;

  always #5 clk_200 = ~clk_200;

  sysmon_drp_poller #(
    .POLL_INTERVAL(POLL), .DRP_TIMEOUT(TMO), .TEMP_HI(T_HI), .TEMP_LO(T_LO)
  ) dut (
    .clk_200(clk_200), .reset(reset),
    .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
    .drp_do(drp_do), .drp_drdy(drp_drdy), .jtag_locked(jtag_locked),
    .temp(temp), .vccint(vccint), .vccaux(vccaux), .vccbram(vccbram),
    .valid(valid), .update(update), .over_temp(over_temp),
    .timeout_err(timeout_err), .sweep_count(sweep_count)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // DRP responder configuration, per sweep index
  logic [15:0] cfg_data [4];
  int          cfg_lat  [4];
  bit          cfg_dead [4];
  logic [7:0]  chan_addr [4];

  // responder state
  bit          pend;
  int          pend_cnt;
  logic [15:0] pend_data;
  int          pend_idx;
  bit          upd_due;
  int          upd_idx;
  logic [15:0] upd_data;
  bit          spur_now;
  logic [7:0]  seen_addr [4];
  int          addr_n;
  int          den_dead_cyc;
  int          to_first;

  // expectation model
  logic [15:0] exp_rd [4];
  logic [3:0]  exp_valid;
  logic        exp_ot;
  logic        exp_to;
  logic [15:0] exp_sc;

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic int idx_of(input logic [7:0] a);
    case (a)
      8'h00:   return 0;
      8'h01:   return 1;
      8'h02:   return 2;
      8'h06:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [15:0] reading_of(input int i);
    case (i)
      0:       return temp;
      1:       return vccint;
      2:       return vccaux;
      3:       return vccbram;
      default: return 16'h0000;
    endcase
  endfunction

  // One clock: sample at the falling edge, check update pulses, act as the DRP slave.
  task automatic step();
    int i;
    @(negedge clk_200);
    cyc++;
    if (upd_due || update) begin
      check_eq("update_pulse", 32'(update), 32'(upd_due));
      if (upd_due) check_eq("capture_value", 32'(reading_of(upd_idx)), 32'(upd_data));
    end
    upd_due  = 1'b0;
    drp_drdy = 1'b0;
    if (reset) pend = 1'b0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        drp_drdy = 1'b1;
        drp_do   = pend_data;
        pend     = 1'b0;
        upd_due  = 1'b1;
        upd_idx  = pend_idx;
        upd_data = pend_data;
      end else begin
        pend_cnt--;
      end
    end
    if (spur_now) begin
      drp_drdy = 1'b1;
      drp_do   = 16'hDEAD;
      spur_now = 1'b0;
    end
    if (drp_den) begin
      if (addr_n < 4) seen_addr[addr_n] = drp_daddr;
      addr_n++;
      i = idx_of(drp_daddr);
      if (i >= 0 && !cfg_dead[i]) begin
        pend      = 1'b1;
        pend_cnt  = cfg_lat[i];
        pend_data = cfg_data[i];
        pend_idx  = i;
      end else begin
        den_dead_cyc = cyc;
      end
    end
    if (timeout_err && to_first < 0) to_first = cyc;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_den"}, 32'(drp_den), 32'd0);
    check_eq({tag, "_daddr"}, 32'(drp_daddr), 32'd0);
    check_eq({tag, "_temp"}, 32'(temp), 32'd0);
    check_eq({tag, "_vccint"}, 32'(vccint), 32'd0);
    check_eq({tag, "_vccaux"}, 32'(vccaux), 32'd0);
    check_eq({tag, "_vccbram"}, 32'(vccbram), 32'd0);
    check_eq({tag, "_valid"}, 32'(valid), 32'd0);
    check_eq({tag, "_update"}, 32'(update), 32'd0);
    check_eq({tag, "_over_temp"}, 32'(over_temp), 32'd0);
    check_eq({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check_eq({tag, "_sweep_count"}, 32'(sweep_count), 32'd0);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    check_all_zero("reset");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) exp_rd[i] = 16'h0000;
    exp_valid = 4'b0000;
    exp_ot    = 1'b0;
    exp_to    = 1'b0;
    exp_sc    = 16'h0000;
    to_first  = -1;
  endtask

  task automatic cfg_fixed();
    for (int i = 0; i < 4; i++) begin
      cfg_data[i] = 16'h1234 + {8'h00, chan_addr[i]};
      cfg_lat[i]  = 3;
      cfg_dead[i] = 1'b0;
    end
  endtask

  task automatic cfg_random(input bit allow_dead);
    for (int i = 0; i < 4; i++) begin
      cfg_data[i] = 16'($urandom);
      cfg_lat[i]  = int'($urandom_range(1, 8));
      cfg_dead[i] = allow_dead && ($urandom_range(0, 7) == 0);
    end
    case ($urandom_range(0, 5))
      0:       cfg_data[0] = T_HI;
      1:       cfg_data[0] = T_HI - 16'd1;
      2:       cfg_data[0] = T_LO;
      3:       cfg_data[0] = T_LO + 16'd1;
      4:       cfg_data[0] = 16'($urandom_range(32'hB400, 32'hB6C0));
      default: cfg_data[0] = 16'($urandom);
    endcase
  endtask

  // Wait (bounded) for the sweep to complete, advance the model, compare everything.
  task automatic run_sweep(input bit fresh);
    logic [15:0] target;
    int n;
    if (fresh) begin
      addr_n = 0;
      for (int i = 0; i < 4; i++) seen_addr[i] = 8'hFF;
    end
    target = exp_sc + 16'd1;
    n = 0;
    while (sweep_count != target && n < 2000) begin
      step();
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      if (cfg_dead[i]) begin
        exp_to = 1'b1;
      end else begin
        exp_rd[i]    = cfg_data[i];
        exp_valid[i] = 1'b1;
      end
    end
    if (!cfg_dead[0]) begin
      if (cfg_data[0] >= T_HI) exp_ot = 1'b1;
      else if (cfg_data[0] <= T_LO) exp_ot = 1'b0;
    end
    exp_sc = target;
    check_eq("sweep_count", 32'(sweep_count), 32'(exp_sc));
    check_eq("den_count", addr_n, 4);
    for (int i = 0; i < 4; i++) check_eq("den_addr", 32'(seen_addr[i]), 32'(chan_addr[i]));
    check_eq("temp", 32'(temp), 32'(exp_rd[0]));
    check_eq("vccint", 32'(vccint), 32'(exp_rd[1]));
    check_eq("vccaux", 32'(vccaux), 32'(exp_rd[2]));
    check_eq("vccbram", 32'(vccbram), 32'(exp_rd[3]));
    check_eq("valid", 32'(valid), 32'(exp_valid));
    check_eq("over_temp", 32'(over_temp), 32'(exp_ot));
    check_eq("timeout_err", 32'(timeout_err), 32'(exp_to));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] temp_seq [3];
    logic        ot_seq   [3];
    int          den_hi;
    int          n;

    chan_addr[0] = 8'h00;
    chan_addr[1] = 8'h01;
    chan_addr[2] = 8'h02;
    chan_addr[3] = 8'h06;
    temp_seq[0] = 16'hB700; ot_seq[0] = 1'b1;
    temp_seq[1] = 16'hB500; ot_seq[1] = 1'b1;
    temp_seq[2] = 16'hB3FF; ot_seq[2] = 1'b0;
    jtag_locked  = 1'b0;
    drp_drdy     = 1'b0;
    drp_do       = 16'h0000;
    pend         = 1'b0;
    upd_due      = 1'b0;
    spur_now     = 1'b0;
    addr_n       = 0;
    den_dead_cyc = -1;
    to_first     = -1;
    cfg_fixed();

    // Reset values, then a sweep with VCCAUX never answering.
    apply_reset(3);
    cfg_fixed();
    cfg_dead[2] = 1'b1;
    run_sweep(1'b1);
    check_eq("timeout_latency", 32'(to_first - den_dead_cyc), TMO);
    check_eq("valid_after_timeout", 32'(valid), 32'h0000000B);

    // Clean sweep with the fixed responder.
    apply_reset(2);
    cfg_fixed();
    run_sweep(1'b1);
    check_eq("temp_fixed", 32'(temp), 32'h00001234);
    check_eq("vccbram_fixed", 32'(vccbram), 32'h0000123A);

    // Over-temperature hysteresis sequence.
    for (int k = 0; k < 3; k++) begin
      cfg_random(1'b0);
      cfg_data[0] = temp_seq[k];
      run_sweep(1'b1);
      check_eq("over_temp_seq", 32'(over_temp), 32'(ot_seq[k]));
    end

    // JTAG holds the DRP while the poller sits in ISSUE.
    cfg_random(1'b0);
    addr_n = 0;
    for (int i = 0; i < 4; i++) seen_addr[i] = 8'hFF;
    jtag_locked = 1'b1;
    den_hi = 0;
    repeat (150) begin
      step();
      if (drp_den) den_hi++;
    end
    check_eq("den_while_locked", den_hi, 0);
    jtag_locked = 1'b0;
    step();
    check_eq("den_after_release", 32'(drp_den), 32'd1);
    check_eq("daddr_after_release", 32'(drp_daddr), 32'h00000000);
    run_sweep(1'b0);

    // Randomized sweeps, occasionally with dead reads.
    repeat (12) begin
      cfg_random(1'b1);
      run_sweep(1'b1);
    end

    // Reset in the middle of a DRDY wait, stray DRDY afterwards.
    cfg_random(1'b0);
    for (int i = 0; i < 4; i++) cfg_lat[i] = 8;
    n = 0;
    while (!drp_den && n < 500) begin
      step();
      n++;
    end
    check_eq("den_before_reset", 32'(drp_den), 32'd1);
    step();
    step();
    apply_reset(2);
    step();
    spur_now = 1'b1;
    repeat (30) step();
    check_all_zero("post_reset");

    // Sweep counter wrap.
    force dut.sweep_cnt_r = 16'hFFFE;
    step();
    release dut.sweep_cnt_r;
    exp_sc = 16'hFFFE;
    cfg_random(1'b0);
    run_sweep(1'b1);
    cfg_random(1'b0);
    run_sweep(1'b1);
    check_eq("sweep_wrap", 32'(sweep_count), 32'h00000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sysmon_drp_poller.md
SYSMON_DRP_POLLER -- requirements
Module: sysmon_drp_poller

Interface
REQ-001 SHALL take parameter POLL_INTERVAL, default 200000; clk_200 cycles from one sweep's start to the next (1 ms).
REQ-002 SHALL take parameter DRP_TIMEOUT, default 63; max clk_200 cycles spent waiting for DRDY per read.
REQ-003 SHALL take parameter TEMP_HI, default 16'hB6C0; raw over-temp set threshold.
REQ-004 SHALL take parameter TEMP_LO, default 16'hB400; raw over-temp clear threshold (TEMP_LO < TEMP_HI).
REQ-005 SHALL have port clk_200, input, 1 bit: 200 MHz utility clock, also the SYSMON DCLK; single clock domain.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-007 SHALL have port drp_daddr, output, 8 bits: SYSMON DRP address.
REQ-008 SHALL have port drp_den, output, 1 bit: DRP enable, one-cycle pulse.
REQ-009 SHALL have port drp_dwe, output, 1 bit: DRP write enable, tied 0.
REQ-010 SHALL have port drp_di, output, 16 bits: DRP write data, tied 0.
REQ-011 SHALL have port drp_do, input, 16 bits: DRP read data.
REQ-012 SHALL have port drp_drdy, input, 1 bit: DRP data ready.
REQ-013 SHALL have port jtag_locked, input, 1 bit: SYSMON JTAGLOCKED; JTAG owns the DRP.
REQ-014 SHALL have ports temp, vccint, vccaux, vccbram, output, 16 bits each: latest raw readings.
REQ-015 SHALL have port valid, output, 4 bits: bit i is 1 once reading i has been captured at least once since reset.
REQ-016 SHALL have port update, output, 1 bit: one-cycle pulse on each captured reading.
REQ-017 SHALL have port over_temp, output, 1 bit: hysteretic over-temperature flag.
REQ-018 SHALL have port timeout_err, output, 1 bit: sticky flag for a DRDY timeout.
REQ-019 SHALL have port sweep_count, output, 16 bits: count of completed sweeps.

Function
REQ-020 SHALL read in sweep order: index 0 temp at 8'h00, index 1 vccint at 8'h01, index 2 vccaux at 8'h02, index 3 vccbram at 8'h06.
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT, CAPTURE, NEXT.
REQ-022 IDLE: SHALL wait until the interval counter reaches POLL_INTERVAL-1, then reset the counter, set index 0, and go to ISSUE; the interval counter runs freely in all states.
REQ-023 ISSUE: SHALL hold while jtag_locked=1 with drp_den=0; otherwise SHALL drive drp_den=1 for exactly one cycle with drp_daddr = address(index), clear the timeout counter, and go to WAIT.
REQ-024 drp_daddr SHALL remain stable from the ISSUE cycle until DRDY or timeout.
REQ-025 WAIT: on drp_drdy=1 SHALL latch drp_do and go to CAPTURE.
REQ-026 WAIT: if DRP_TIMEOUT cycles elapse without drp_drdy, SHALL set timeout_err, leave the reading register and its valid bit unchanged, and go to NEXT.
REQ-027 CAPTURE: the register for index SHALL update, valid[index] SHALL set, and update SHALL pulse one cycle after the DRDY cycle (latency 1); SHALL then go to NEXT.
REQ-028 NEXT: if index<3, SHALL increment index and go to ISSUE; if index=3, SHALL increment sweep_count (wraps FFFF->0000) and go to IDLE.
REQ-029 drp_drdy outside WAIT SHALL be ignored.
REQ-030 over_temp SHALL set when a captured temp >= TEMP_HI, clear when a captured temp <= TEMP_LO, and otherwise hold; it updates in the same cycle as temp.
REQ-031 If a sweep overruns POLL_INTERVAL, the next sweep SHALL start at the first interval expiry observed in IDLE; no sweep is queued or dropped-twice.
REQ-032 timeout_err SHALL be cleared only by reset.

Reset
REQ-033 reset SHALL asynchronously force state IDLE, index 0, both counters 0, and all outputs to 0: drp_den, drp_daddr, the readings, valid, update, over_temp, timeout_err, sweep_count.
REQ-034 Reset during WAIT SHALL abandon the read; a drp_drdy arriving after reset release SHALL be ignored.

Structure
REQ-035 A shared package sysmon_pkg SHALL hold the FSM state enum, the 4-entry address table, and the index constants.
REQ-036 The block SHALL be a single module with no sub-modules; it connects to the existing SYSMONE1 DRP pins, DCLK = clk_200.

Verification
REQ-037 POLL_INTERVAL=100 and a DRP model returning DRDY 3 cycles after DEN with data 16'h1234 + addr SHALL produce DEN at addresses 00, 01, 02, 06, give temp=1234 and vccbram=123A, drive valid to F, and give sweep_count=1.
REQ-038 Model that never asserts DRDY for addr 02 SHALL set timeout_err after 63 cycles, leave valid=4'b1011, and still complete the sweep.
REQ-039 jtag_locked=1 for 50 cycles during ISSUE SHALL keep drp_den low throughout, with the read issued on the first cycle after release.
REQ-040 Successive temp reads B700, B500, B3FF SHALL give over_temp 1, 1, 0.
REQ-041 reset asserted mid-WAIT with DRDY 2 cycles after release SHALL leave all outputs 0 and update never pulsing.
REQ-042 Forcing 65536 sweeps SHALL wrap sweep_count to 0000.
